// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller: FSM encoding,
// requester ids and default timing parameters.
package dmem_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccCpu = 2'd1,
        StAccLdr = 2'd2,
        StResp   = 2'd3
    } dmem_state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    localparam int unsigned WAIT_CYC_DEF   = 1;
    localparam int unsigned STARVE_LIM_DEF = 3;

endpackage

// File: rtl/dmem_wait_timer.sv
// Wait-state timer: loaded at grant, counts down once per access cycle and
// flags 'expire' on the cycle the count sits at zero.
module dmem_wait_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       expire
);

    logic [2:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 3'd0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != 3'd0)) begin
            count_q <= count_q - 3'd1;
        end
    end

    assign expire = (count_q == 3'd0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: arbitrates CPU MEM stage vs loader port,
// holds memory strobes for WAIT_CYC+1 cycles and pulses ack/done afterwards.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned WAIT_CYC   = WAIT_CYC_DEF,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_rm,
    input  logic              cpu_wm,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_done,
    output logic              mem_rm,
    output logic              mem_wm,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned    SW        = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0]  StarveMax = SW'(STARVE_LIM);
    localparam logic [2:0]     WaitLoad  = 3'(WAIT_CYC);

    dmem_state_e   state_q, state_d;
    logic          owner_q;
    logic [SW-1:0] starve_q;
    logic          cpu_req, grant_cpu, grant_ldr, acc_done, in_acc, expire;

    assign cpu_req  = cpu_rm | cpu_wm;
    assign in_acc   = (state_q == StAccCpu) || (state_q == StAccLdr);
    assign cpu_ack  = (state_q == StResp) && (owner_q == REQ_CPU);
    assign ldr_done = (state_q == StResp) && (owner_q == REQ_LDR);
    assign stall    = cpu_req & ~cpu_ack;

    dmem_wait_timer u_wait_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (grant_cpu | grant_ldr),
        .load_val (WaitLoad),
        .dec      (in_acc),
        .expire   (expire)
    );

    always_comb begin
        state_d   = state_q;
        grant_cpu = 1'b0;
        grant_ldr = 1'b0;
        acc_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Loader only overrides the CPU once it has been passed over STARVE_LIM times.
                if (ldr_req && (!cpu_req || (starve_q == StarveMax))) begin
                    grant_ldr = 1'b1;
                    state_d   = StAccLdr;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                    state_d   = StAccCpu;
                end
            end
            StAccCpu, StAccLdr: begin
                if (expire) begin
                    acc_done = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q   <= REQ_CPU;
            starve_q  <= '0;
            mem_rm    <= 1'b0;
            mem_wm    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
        end else begin
            if (!ldr_req || grant_ldr) begin
                starve_q <= '0;
            end else if (grant_cpu && (starve_q != StarveMax)) begin
                starve_q <= starve_q + SW'(1);
            end

            if (grant_cpu) begin
                // Simultaneous read+write is a plain write.
                owner_q   <= REQ_CPU;
                mem_rm    <= cpu_rm & ~cpu_wm;
                mem_wm    <= cpu_wm;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (grant_ldr) begin
                owner_q   <= REQ_LDR;
                mem_rm    <= ~ldr_we;
                mem_wm    <= ldr_we;
                mem_addr  <= ldr_addr;
                mem_wdata <= ldr_wdata;
            end else if (acc_done) begin
                mem_rm <= 1'b0;
                mem_wm <= 1'b0;
                if (owner_q == REQ_CPU) begin
                    cpu_rdata <= mem_rm ? mem_rdata : '0;
                end else begin
                    ldr_rdata <= mem_rm ? mem_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a behavioural memory and
// a reference model of memory contents, latency and arbitration order.
module tb_dmem_access_ctrl;

    localparam int unsigned W   = 1;
    localparam int unsigned LIM = 3;
    localparam int          LAT = W + 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_rm, cpu_wm, ldr_req, ldr_we;
    logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, stall, ldr_done, mem_rm, mem_wm;

    logic [15:0] mem_arr [0:65535];
    logic [15:0] ref_mem [logic [15:0]];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign mem_rdata = mem_rm ? mem_arr[mem_addr] : 16'h0000;
    always @(posedge clock) if (mem_wm) mem_arr[mem_addr] <= mem_wdata;

    dmem_access_ctrl #(
        .DATA_W     (16),
        .ADDR_W     (16),
        .WAIT_CYC   (W),
        .STARVE_LIM (LIM)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cpu_rm    (cpu_rm),
        .cpu_wm    (cpu_wm),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .stall     (stall),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_rdata (ldr_rdata),
        .ldr_done  (ldr_done),
        .mem_rm    (mem_rm),
        .mem_wm    (mem_wm),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    // Called just after a rising edge; that cycle is cycle 0 of the access.
    task automatic cpu_access(input logic rm, input logic wm, input logic [15:0] a,
                              input logic [15:0] d, output int ack_cyc,
                              output logic [15:0] rd, output int rm_cnt, output int wm_cnt,
                              output int stall_cnt);
        ack_cyc = -1; rd = 16'hxxxx; rm_cnt = 0; wm_cnt = 0; stall_cnt = 0;
        cpu_rm = rm; cpu_wm = wm; cpu_addr = a; cpu_wdata = d;
        for (int c = 0; c < 20 && ack_cyc < 0; c++) begin
            @(negedge clock);
            if (mem_rm) rm_cnt++;
            if (mem_wm) wm_cnt++;
            if (stall) stall_cnt++;
            if (cpu_ack) begin ack_cyc = c; rd = cpu_rdata; end
            @(posedge clock); #1;
        end
        cpu_rm = 1'b0; cpu_wm = 1'b0;
    endtask

    task automatic ldr_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                              output int done_cyc, output logic [15:0] rd,
                              output int rm_cnt, output int wm_cnt, output int stall_cnt);
        done_cyc = -1; rd = 16'hxxxx; rm_cnt = 0; wm_cnt = 0; stall_cnt = 0;
        ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
        for (int c = 0; c < 20 && done_cyc < 0; c++) begin
            @(negedge clock);
            if (mem_rm) rm_cnt++;
            if (mem_wm) wm_cnt++;
            if (stall) stall_cnt++;
            if (ldr_done) begin done_cyc = c; rd = ldr_rdata; end
            @(posedge clock); #1;
        end
        ldr_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_rm = 0; cpu_wm = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if ({mem_rm, mem_wm, cpu_ack, ldr_done, stall} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b expected 00000",
                               {mem_rm, mem_wm, cpu_ack, ldr_done, stall});
        end
        checks++; if ({mem_addr, mem_wdata} !== 32'h0) begin
            errors++; $display("FAIL reset_mem_bus got %h expected 0", {mem_addr, mem_wdata});
        end
        checks++; if ({cpu_rdata, ldr_rdata} !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h expected 0", {cpu_rdata, ldr_rdata});
        end
        reset = 1'b0;
        @(negedge clock);
        checks++; if ({mem_rm, mem_wm, cpu_ack, ldr_done} !== 4'b0) begin
            errors++; $display("FAIL idle_after_reset got %b expected 0000",
                               {mem_rm, mem_wm, cpu_ack, ldr_done});
        end
        @(posedge clock); #1;
    endtask

    task automatic test_cpu_read();
        int ack, rmc, wmc, stc;
        logic [15:0] rd;
        mem_arr[16'h0010] = 16'hBEEF; ref_mem[16'h0010] = 16'hBEEF;
        cpu_access(1'b1, 1'b0, 16'h0010, 16'h0000, ack, rd, rmc, wmc, stc);
        checks++; if (ack !== LAT) begin errors++; $display("FAIL read_latency got %0d expected %0d", ack, LAT); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL read_data got %h expected beef", rd); end
        checks++; if (rmc !== W + 1) begin errors++; $display("FAIL read_strobe_len got %0d expected %0d", rmc, W + 1); end
        checks++; if (wmc !== 0) begin errors++; $display("FAIL read_no_wm got %0d expected 0", wmc); end
        checks++; if (stc !== LAT) begin errors++; $display("FAIL read_stall_len got %0d expected %0d", stc, LAT); end
        @(negedge clock);
        checks++; if ({cpu_ack, cpu_rdata} !== {1'b0, 16'hBEEF}) begin
            errors++; $display("FAIL read_hold got ack=%b data=%h expected ack=0 data=beef", cpu_ack, cpu_rdata);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_write();
        int ack, rmc, wmc, stc;
        logic [15:0] rd;
        cpu_access(1'b0, 1'b1, 16'h0004, 16'h1234, ack, rd, rmc, wmc, stc);
        ref_mem[16'h0004] = 16'h1234;
        checks++; if (ack !== LAT) begin errors++; $display("FAIL write_latency got %0d expected %0d", ack, LAT); end
        checks++; if (wmc !== W + 1 || rmc !== 0) begin
            errors++; $display("FAIL write_strobes got wm=%0d rm=%0d expected wm=%0d rm=0", wmc, rmc, W + 1);
        end
        checks++; if (mem_arr[16'h0004] !== 16'h1234) begin
            errors++; $display("FAIL write_mem got %h expected 1234", mem_arr[16'h0004]);
        end
        cpu_access(1'b1, 1'b0, 16'h0004, 16'h0000, ack, rd, rmc, wmc, stc);
        checks++; if (rd !== ref_rd(16'h0004)) begin
            errors++; $display("FAIL write_readback got %h expected %h", rd, ref_rd(16'h0004));
        end
    endtask

    task automatic test_loader_only();
        int dn, rmc, wmc, stc;
        logic [15:0] rd;
        ldr_access(1'b1, 16'hFFFF, 16'hA5A5, dn, rd, rmc, wmc, stc);
        ref_mem[16'hFFFF] = 16'hA5A5;
        checks++; if (dn !== LAT) begin errors++; $display("FAIL ldr_latency got %0d expected %0d", dn, LAT); end
        checks++; if (stc !== 0) begin errors++; $display("FAIL ldr_stall got %0d cycles expected 0", stc); end
        checks++; if (wmc !== W + 1) begin errors++; $display("FAIL ldr_wm_len got %0d expected %0d", wmc, W + 1); end
        checks++; if (mem_arr[16'hFFFF] !== 16'hA5A5) begin
            errors++; $display("FAIL ldr_mem got %h expected a5a5", mem_arr[16'hFFFF]);
        end
        ldr_access(1'b0, 16'hFFFF, 16'h0000, dn, rd, rmc, wmc, stc);
        checks++; if (rd !== ref_rd(16'hFFFF)) begin
            errors++; $display("FAIL ldr_readback got %h expected %h", rd, ref_rd(16'hFFFF));
        end
    endtask

    task automatic test_both_rw();
        int ack, rmc, wmc, stc;
        logic [15:0] rd;
        cpu_access(1'b1, 1'b1, 16'h0008, 16'h00FF, ack, rd, rmc, wmc, stc);
        ref_mem[16'h0008] = 16'h00FF;
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rw_rdata got %h expected 0000", rd); end
        checks++; if (wmc !== W + 1 || rmc !== 0) begin
            errors++; $display("FAIL rw_strobes got wm=%0d rm=%0d expected wm=%0d rm=0", wmc, rmc, W + 1);
        end
        checks++; if (mem_arr[16'h0008] !== 16'h00FF) begin
            errors++; $display("FAIL rw_mem got %h expected 00ff", mem_arr[16'h0008]);
        end
    endtask

    task automatic test_contention();
        byte who [8];
        int cyc [8];
        logic [15:0] dat [8];
        int n = 0;
        int starve = 0;
        byte exp_who;
        logic [15:0] exp_dat;
        cpu_rm = 1'b1; cpu_wm = 1'b0; cpu_addr = 16'h0010;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'hFFFF;
        for (int c = 0; c < 60 && n < 8; c++) begin
            @(negedge clock);
            checks++; if (cpu_ack && ldr_done) begin
                errors++; $display("FAIL contention_overlap cycle %0d got both pulses expected one", c);
            end
            if (cpu_ack) begin who[n] = "C"; cyc[n] = c; dat[n] = cpu_rdata; n++; end
            else if (ldr_done) begin who[n] = "L"; cyc[n] = c; dat[n] = ldr_rdata; n++; end
            @(posedge clock); #1;
        end
        cpu_rm = 1'b0; ldr_req = 1'b0;
        checks++; if (n !== 8) begin errors++; $display("FAIL contention_count got %0d expected 8", n); end
        for (int k = 0; k < n; k++) begin
            if (starve == int'(LIM)) begin exp_who = "L"; starve = 0; end
            else begin exp_who = "C"; starve++; end
            exp_dat = (exp_who == "C") ? ref_rd(16'h0010) : ref_rd(16'hFFFF);
            checks++; if (who[k] !== exp_who) begin
                errors++; $display("FAIL contention_order[%0d] got %c expected %c", k, who[k], exp_who);
            end
            checks++; if (cyc[k] !== LAT + k * (LAT + 1)) begin
                errors++; $display("FAIL contention_time[%0d] got %0d expected %0d", k, cyc[k], LAT + k * (LAT + 1));
            end
            checks++; if (dat[k] !== exp_dat) begin
                errors++; $display("FAIL contention_data[%0d] got %h expected %h", k, dat[k], exp_dat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ack, rmc, wmc, stc;
        logic [15:0] rd;
        cpu_rm = 1'b1; cpu_wm = 1'b0; cpu_addr = 16'h0010;
        @(posedge clock); #1;
        checks++; if (mem_rm !== 1'b1) begin errors++; $display("FAIL mid_pre_strobe got %b expected 1", mem_rm); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_rm !== 1'b0) begin errors++; $display("FAIL mid_async_drop got %b expected 0", mem_rm); end
        repeat (2) begin
            @(negedge clock);
            checks++; if ({cpu_ack, mem_rm} !== 2'b00) begin
                errors++; $display("FAIL mid_no_ack got %b expected 00", {cpu_ack, mem_rm});
            end
        end
        @(posedge clock); #1;
        reset = 1'b0;
        cpu_access(1'b1, 1'b0, 16'h0010, 16'h0000, ack, rd, rmc, wmc, stc);
        checks++; if (ack !== LAT) begin errors++; $display("FAIL mid_restart_latency got %0d expected %0d", ack, LAT); end
        checks++; if (rd !== ref_rd(16'h0010)) begin
            errors++; $display("FAIL mid_restart_data got %h expected %h", rd, ref_rd(16'h0010));
        end
    endtask

    task automatic test_random();
        int lat, rmc, wmc, stc, kind;
        logic [15:0] a, d, rd, exp_rd;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            a = 16'h0100 + 16'($urandom_range(0, 7));
            d = 16'($urandom);
            kind = $urandom_range(0, 4);
            if (kind <= 2) begin
                exp_rd = (kind == 0) ? ref_rd(a) : 16'h0000;
                cpu_access(kind != 1, kind != 0, a, d, lat, rd, rmc, wmc, stc);
            end else begin
                exp_rd = (kind == 3) ? ref_rd(a) : 16'h0000;
                ldr_access(kind == 4, a, d, lat, rd, rmc, wmc, stc);
            end
            if (kind != 0 && kind != 3) ref_mem[a] = d;
            checks++; if (lat !== LAT) begin
                errors++; $display("FAIL rand_latency[%0d] kind %0d got %0d expected %0d", i, kind, lat, LAT);
            end
            if (kind == 0 || kind == 3) begin
                checks++; if (rd !== exp_rd) begin
                    errors++; $display("FAIL rand_rdata[%0d] addr %h got %h expected %h", i, a, rd, exp_rd);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0000;
        test_reset();
        test_cpu_read();
        test_write();
        test_loader_only();
        test_both_rw();
        test_contention();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
